// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path: segment vector type
// and the active-low glyph patterns, ordered {g,f,e,d,c,b,a}.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_A     = 7'b0001000;
  localparam seg_t SEG_B     = 7'b0000011;
  localparam seg_t SEG_C     = 7'b1000110;
  localparam seg_t SEG_D     = 7'b0100001;
  localparam seg_t SEG_E     = 7'b0000110;
  localparam seg_t SEG_F     = 7'b0001110;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational 4-bit code to active-low glyph decoder. Codes 10-15 show as
// hex letters when hex_mode is set, otherwise as a dash.
module seg7_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  input  logic       hex_mode,
  output seg_t       seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (code)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB:    seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC:    seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD:    seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE:    seg = hex_mode ? SEG_E : SEG_DASH;
      4'hF:    seg = hex_mode ? SEG_F : SEG_DASH;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// N-digit time-multiplexed common-anode seven-segment driver with
// double-buffered (frame-aligned) updates, leading-zero blanking and blink.
module seven_seg_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic                    load,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [SEG_W-1:0]        segments,
  output logic [NUM_DIGITS-1:0]   display_select
);

  localparam int DW    = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int FC_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(BLINK_DIV - 1);

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [FC_W-1:0]       fcnt_q, fcnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [DW-1:0]         pend_q, pend_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [DW-1:0]         shadow_q, shadow_d;
  seg_t                  seg_q, seg_d;
  logic [NUM_DIGITS-1:0] sel_q, sel_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] lz_mask;
  logic [3:0]            cur_code;
  logic                  cur_blank;
  seg_t                  glyph;

  // Digit g is a leading zero when it and everything above it are zero.
  assign lz_mask[0] = 1'b0;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign nib[g] = shadow_q[4*g +: 4];
    if (g > 0) begin : g_lz
      assign lz_mask[g] = (shadow_q[DW-1:4*g] == '0);
    end
  end

  always_comb begin
    cur_code  = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_code  = nib[i];
        cur_blank = (blank_lz & lz_mask[i]) | (blink_phase_q & blink_mask[i]);
      end
    end
  end

  seg7_decoder u_dec (
    .code     (cur_code),
    .hex_mode (hex_mode),
    .seg      (glyph)
  );

  assign slot_end  = (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d         = slot_end ? '0 : cnt_q + 1'b1;
    idx_d         = idx_q;
    fcnt_d        = fcnt_q;
    blink_phase_d = blink_phase_q;
    pend_d        = pend_q;
    pend_valid_d  = pend_valid_q;
    shadow_d      = shadow_q;

    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end

    if (frame_end) begin
      if (fcnt_q == FC_LAST) begin
        fcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end

    // A load landing on the frame boundary bypasses pending so it is not lost.
    if (load && frame_end) begin
      shadow_d     = bcd_in;
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_d       = bcd_in;
      pend_valid_d = 1'b1;
    end else if (frame_end && pend_valid_q) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
    end
  end

  // Output stage: one cycle behind the scan position; last slot cycle is dark.
  always_comb begin
    seg_d = cur_blank ? SEG_BLANK : glyph;
    sel_d = '1;
    if (!slot_end) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        sel_d[i] = (idx_q != IDX_W'(i));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q         <= '0;
      idx_q         <= '0;
      fcnt_q        <= '0;
      blink_phase_q <= 1'b0;
      pend_q        <= '0;
      pend_valid_q  <= 1'b0;
      shadow_q      <= '0;
      seg_q         <= SEG_BLANK;
      sel_q         <= '1;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      fcnt_q        <= fcnt_d;
      blink_phase_q <= blink_phase_d;
      pend_q        <= pend_d;
      pend_valid_q  <= pend_valid_d;
      shadow_q      <= shadow_d;
      seg_q         <= seg_d;
      sel_q         <= sel_d;
    end
  end

  assign segments       = seg_q;
  assign display_select = sel_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a cycle-indexed reference model
// checked every clock, plus hand-computed expectations at chosen cycles.
module tb_seven_seg_scanner;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int B  = 2;
  localparam int NR = N * R;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load = 1'b0;
  logic        hex_mode = 1'b0;
  logic        blank_lz = 1'b0;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  blink_mask = 4'h0;
  logic [6:0]  segments;
  logic [3:0]  display_select;

  int checks = 0;
  int errors = 0;
  int mcyc = 0;

  typedef struct {
    int          c;
    logic [15:0] v;
  } load_t;
  load_t loads[$];

  always #5 clk = ~clk;

  seven_seg_scanner #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLINK_DIV   (B)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .bcd_in         (bcd_in),
    .load           (load),
    .hex_mode       (hex_mode),
    .blank_lz       (blank_lz),
    .blink_mask     (blink_mask),
    .segments       (segments),
    .display_select (display_select)
  );

  function automatic logic [6:0] glyph_of(input logic [3:0] code, input logic hx);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    if (!hx && code > 4'h9) s = 7'b0111111;
    return s;
  endfunction

  // Reference model: output after edge c shows position c of the frame
  // schedule; a frame shows the last value loaded in any earlier frame.
  logic [6:0]  m_seg;
  logic [3:0]  m_sel;
  int          m_c, m_pos, m_idx, m_cnt, m_f;
  logic [15:0] m_sh;
  logic [3:0]  m_nib;
  logic        m_blank;

  always @(posedge clk) begin
    if (!reset) begin
      m_seg = 7'h7F;
      m_sel = 4'hF;
      mcyc  = 0;
      loads.delete();
    end else begin
      m_c   = mcyc;
      m_pos = m_c % NR;
      m_idx = m_pos / R;
      m_cnt = m_pos % R;
      m_f   = m_c / NR;
      m_sh  = 16'h0000;
      foreach (loads[i]) begin
        if (loads[i].c / NR < m_f) m_sh = loads[i].v;
      end
      m_nib   = 4'(m_sh >> (4 * m_idx));
      m_blank = (blank_lz && m_idx != 0 && (m_sh >> (4 * m_idx)) == 16'h0000)
             || (((m_f / B) % 2 == 1) && ((blink_mask >> m_idx) & 4'd1) != 4'd0);
      m_seg = m_blank ? 7'h7F : glyph_of(m_nib, hex_mode);
      m_sel = (m_cnt == R - 1) ? 4'hF : (4'hF & ~(4'b0001 << m_idx));
      if (load) loads.push_back('{m_c, bcd_in});
      mcyc = mcyc + 1;
    end
    #1;
    checks++;
    if (segments !== m_seg) begin
      errors++;
      $display("FAIL model_seg c=%0d: got %b want %b", mcyc - 1, segments, m_seg);
    end
    checks++;
    if (display_select !== m_sel) begin
      errors++;
      $display("FAIL model_sel c=%0d: got %b want %b", mcyc - 1, display_select, m_sel);
    end
  end

  task automatic lit(input string nm, input logic [10:0] want);
    checks++;
    if ({display_select, segments} !== want) begin
      errors++;
      $display("FAIL %s: got sel=%b seg=%b want sel=%b seg=%b",
               nm, display_select, segments, want[10:7], want[6:0]);
    end
  endtask

  // Returns at the falling edge following rising edge number k.
  task automatic at_cyc(input int k);
    int n;
    n = 0;
    while (mcyc <= k && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (mcyc <= k) begin
      checks++;
      errors++;
      $display("FAIL wait_c%0d: got cycle %0d want %0d", k, mcyc, k + 1);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    lit("reset_hold", {4'b1111, 7'b1111111});
    reset = 1'b1; load = 1'b1; bcd_in = 16'h1998;
    @(negedge clk); load = 1'b0;
    lit("first_edge", {4'b1110, 7'b1000000});
    at_cyc(16); lit("scan_d0_8",   {4'b1110, 7'b0000000});
    at_cyc(19); lit("dead_cycle",  {4'b1111, 7'b0000000});
    at_cyc(20); lit("scan_d1_9",   {4'b1101, 7'b0010000});
    at_cyc(28); lit("scan_d3_1",   {4'b0111, 7'b1111001});

    at_cyc(36); load = 1'b1; bcd_in = 16'h0930;
    at_cyc(37); load = 1'b0;
    at_cyc(40); lit("tear_old_d2", {4'b1011, 7'b0010000});
    at_cyc(44); lit("tear_old_d3", {4'b0111, 7'b1111001});
    at_cyc(48); lit("tear_new_d0", {4'b1110, 7'b1000000});
    at_cyc(52); lit("tear_new_d1", {4'b1101, 7'b0110000});
    at_cyc(60); lit("tear_new_d3", {4'b0111, 7'b1000000});

    at_cyc(64); blank_lz = 1'b1;
    at_cyc(66); load = 1'b1; bcd_in = 16'h0000;
    at_cyc(67); load = 1'b0;
    at_cyc(72); lit("lz_d2_9",     {4'b1011, 7'b0010000});
    at_cyc(76); lit("lz_d3_blank", {4'b0111, 7'b1111111});
    at_cyc(80); lit("zero_d0",     {4'b1110, 7'b1000000});
    at_cyc(82); load = 1'b1; bcd_in = 16'h000B;
    at_cyc(83); load = 1'b0;
    at_cyc(84); lit("zero_d1",     {4'b1101, 7'b1111111});
    at_cyc(96); lit("b_dash",      {4'b1110, 7'b0111111});
    at_cyc(97); hex_mode = 1'b1;
    at_cyc(98); lit("b_hex",       {4'b1110, 7'b0000011});
    at_cyc(99); lit("b_hex_dead",  {4'b1111, 7'b0000011});

    at_cyc(114); load = 1'b1; bcd_in = 16'h1111;
    at_cyc(115); load = 1'b0;
    at_cyc(126); load = 1'b1; bcd_in = 16'h4321;
    at_cyc(127); load = 1'b0;
    at_cyc(128); lit("simul_d0_1", {4'b1110, 7'b1111001});
    at_cyc(132); lit("simul_d1_2", {4'b1101, 7'b0100100});
    at_cyc(136); lit("simul_d2_3", {4'b1011, 7'b0110000});
    at_cyc(140); lit("simul_d3_4", {4'b0111, 7'b0011001});

    at_cyc(144); load = 1'b1; bcd_in = 16'h5555;
    at_cyc(145); load = 1'b0;
    at_cyc(147); reset = 1'b0;
    @(negedge clk);
    lit("reset_mid", {4'b1111, 7'b1111111});
    blank_lz = 1'b0; hex_mode = 1'b0; blink_mask = 4'b0001;
    @(negedge clk);
    reset = 1'b1; load = 1'b1; bcd_in = 16'h1998;
    @(negedge clk); load = 1'b0;
    lit("post_reset_d0", {4'b1110, 7'b1000000});
    at_cyc(16); lit("blink_f1_on",  {4'b1110, 7'b0000000});
    at_cyc(32); lit("blink_f2_off", {4'b1110, 7'b1111111});
    at_cyc(36); lit("blink_other",  {4'b1101, 7'b0010000});
    at_cyc(48); lit("blink_f3_off", {4'b1110, 7'b1111111});
    at_cyc(64); lit("blink_f4_on",  {4'b1110, 7'b0000000});
    at_cyc(70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seven_seg_scanner.md
# seven_seg_scanner

Parametrised, time-multiplexed driver for common-anode seven-segment displays, generalising the fixed 4-digit BCD display multiplexer to N digits. It sits between the arithmetic/BCD-conversion datapath and the board's segment/anode pins. It adds tear-free double-buffered updates, hex/BCD glyph modes, leading-zero blanking, per-digit blink and an anti-ghosting dead cycle.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (2..8).
- REFRESH_DIV, 50000: clock cycles per digit slot (≥ 2).
- BLINK_DIV, 32: frames per blink half-period (≥ 1).
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- bcd_in  in  4*NUM_DIGITS  digit codes; nibble i = digit i, with nibble 0 the least significant.
- load  in  1  single-cycle strobe; captures bcd_in.
- hex_mode  in  1  1: codes 10–15 render as A–F; 0: they render as a dash.
- blank_lz  in  1  enables leading-zero blanking.
- blink_mask  in  NUM_DIGITS  bit i set makes digit i blink.
- segments  out  7  {g,f,e,d,c,b,a}, active-low.
- display_select  out  NUM_DIGITS  anode enables, active-low one-hot; bit i = digit i.

## Operation
- Slot counter cnt runs 0..REFRESH_DIV-1. On terminal count it wraps to 0, and digit index idx advances, wrapping from NUM_DIGITS-1 to 0.
- Frame boundary is the cycle where cnt is terminal and idx = NUM_DIGITS-1.
- Buffering:
  - load writes bcd_in into the pending register and sets pend_valid.
  - At each frame boundary, if pend_valid is set, shadow <= pending and pend_valid clears.
  - If load coincides with a frame boundary, bcd_in goes directly into shadow and pend_valid clears.
  - A second load before the boundary overwrites pending; the last one wins.
- Glyphs (active-low) come from shadow nibble idx:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001
  - 5 = 0010010, 6 = 0000010, 7 = 1111000, 8 = 0000000, 9 = 0010000
  - hex A–F = 0001000, 0000011, 1000110, 0100001, 0000110, 0001110
  - dash = 0111111; blank = 1111111.
- Leading-zero blanking (blank_lz = 1):
  - A digit is blanked when it and every more-significant digit in shadow are 0.
  - Digit 0 is never blanked by this rule.
- Blink:
  - A frame counter toggles blink_phase every BLINK_DIV frames.
  - While blink_phase = 1, digits with blink_mask set are blanked. blink_mask is sampled live.
- Dead cycle: when cnt = REFRESH_DIV-1, display_select is all ones (anti-ghosting). segments still carries the current glyph.
- A blanked digit keeps its anode asserted, and segments = 1111111.
- hex_mode and blank_lz are sampled live each cycle.

## Timing
- All outputs are registered, with one cycle of latency from (cnt, idx, shadow) to the pins.
- Reset (reset = 0 at an edge) clears cnt, idx, blink_phase, frame counter, pending, shadow and pend_valid to 0. segments = 1111111 and display_select = all ones.
- The first edge after reset release drives display_select = …1110 and segments = glyph of digit 0 (the 0 glyph, since shadow = 0).
- Each digit is lit for REFRESH_DIV-1 cycles, followed by one dead cycle. The frame period is NUM_DIGITS*REFRESH_DIV.
- A new value is visible starting at the first slot of the frame after the boundary that transfers it. Digits of a single frame never mix old and new values.
- Reset mid-frame discards pending data without transferring it; outputs are all off on the next edge.

## Structure
- Shared package seg_pkg:
  - SEG_W = 7
  - glyph localparams (SEG_0..SEG_9, SEG_A..SEG_F, SEG_DASH, SEG_BLANK)
  - typedef seg_t
- Sub-module seg7_decoder (combinational): code[3:0] + hex_mode -> seg_t. The scanner instantiates it once on the selected nibble.
- The leading-zero mask is a generate loop over NUM_DIGITS inside the scanner.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=4, BLINK_DIV=2.
- Reset and scan:
  - Stimulus: hold reset = 0 for 3 cycles, release, load 0x1998.
  - Response: display_select before release = 1111. After the first boundary it cycles 1110→1101→1011→0111, each lit 3 cycles with 1 dead cycle. Digits 0..3 show 8, 9, 9, 1 (0000000, 0010000, 0010000, 1111001).
- Tear-free update:
  - Stimulus: load 0x0930 mid-frame (idx = 1).
  - Response: the remainder of the frame shows 1998. The next frame shows 0, 3, 9, 0.
- Leading-zero blanking and modes:
  - Stimulus: shadow 0x0930 with blank_lz = 1.
  - Response: digit 3 shows 1111111, and digits 2..0 show 9, 3, 0.
  - Stimulus: shadow 0x0000 with blank_lz = 1.
  - Response: only digit 0 shows 1000000.
  - Stimulus: nibble 0xB with hex_mode = 0.
  - Response: 0111111.
  - Stimulus: the same nibble with hex_mode = 1.
  - Response: 0000011.
- Blink:
  - Stimulus: blink_mask = 0001.
  - Response: digit 0 is visible for frames 0–1, blank for frames 2–3, visible again in frame 4. The other digits are unaffected.
- Simultaneous load and boundary:
  - Stimulus: load 0x4321 exactly at the frame-boundary cycle, while 0x1111 is pending.
  - Response: the next frame shows 1, 2, 3, 4, and 0x1111 is never displayed.
- Reset mid-operation:
  - Stimulus: assert reset with pend_valid = 1.
  - Response: outputs are all ones the next edge. After release, digit 0 shows 0 and the pending value never appears.
